// File: rtl/ico_spi_ctrl_pkg.sv
// Shared types and constants for the icoboard SPI control front end.
// The optional ID byte feature is selected by the ICO_SPI_CTRL_ID_EN macro.
package ico_spi_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_WAIT = 3'd0,
        ST_IDLE = 3'd1,
        ST_CMD  = 3'd2,
        ST_HDR  = 3'd3,
        ST_DATA = 3'd4
    } state_t;

    localparam logic [7:0] ID_BYTE_DEFAULT = 8'hA5;

endpackage

// File: rtl/ico_sync2.sv
// Two-flop synchroniser with asynchronous active-low reset and a
// configurable reset value, for bringing SPI pins into the clk domain.
module ico_sync2 #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic resetn,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/ico_spi_ctrl.sv
// SPI slave (mode 0) front end for the icoboard control bus.
// Define ICO_SPI_CTRL_ID_EN to return ID_BYTE on MISO during the command byte.
module ico_spi_ctrl
    import ico_spi_ctrl_pkg::*;
#(
    parameter int         NUM_EP  = 2,
    parameter logic [7:0] ID_BYTE = ID_BYTE_DEFAULT
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              spi_sclk,
    input  logic              spi_csn,
    input  logic              spi_mosi,
    output logic              spi_miso,
    output logic              spi_ctrl_si,
    output logic              spi_ctrl_so,
    output logic              spi_ctrl_hd,
    output logic [7:0]        spi_ctrl_di,
    input  logic [7:0]        spi_ctrl_do,
    output logic [NUM_EP-1:0] epsel
);

`ifdef ICO_SPI_CTRL_ID_EN
    localparam bit ID_EN = 1'b1;
`else
    localparam bit ID_EN = 1'b0;
`endif

    logic        sclk_s, csn_s, mosi_s;
    logic        sclk_q;
    logic        sclk_rise, sclk_fall;
    state_t      state;
    logic [1:0]  wait_cnt;
    logic [2:0]  bit_cnt;
    logic [6:0]  rx_sr;
    logic [7:0]  rx_next;
    logic [7:0]  tx_sr;
    logic [NUM_EP-1:0] cmd_dec;

    ico_sync2 #(.RESET_VAL(1'b0)) u_sync_sclk (.clk(clk), .resetn(resetn), .d(spi_sclk), .q(sclk_s));
    ico_sync2 #(.RESET_VAL(1'b1)) u_sync_csn  (.clk(clk), .resetn(resetn), .d(spi_csn),  .q(csn_s));
    ico_sync2 #(.RESET_VAL(1'b0)) u_sync_mosi (.clk(clk), .resetn(resetn), .d(spi_mosi), .q(mosi_s));

    assign sclk_rise = sclk_s & ~sclk_q;
    assign sclk_fall = ~sclk_s & sclk_q;
    assign rx_next   = {rx_sr, mosi_s};

    always_comb begin
        cmd_dec = '0;
        for (int i = 0; i < NUM_EP; i++) begin
            if (rx_next == 8'(i + 1)) cmd_dec[i] = 1'b1;
        end
    end

    // Byte bus: si is a one-cycle strobe with di (and hd for the header byte);
    // so follows si by one cycle, and spi_ctrl_do is captured in that so cycle
    // as the reply shifted out during the next byte. There is no back-pressure.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state       <= ST_WAIT;
            wait_cnt    <= 2'd0;
            sclk_q      <= 1'b0;
            bit_cnt     <= 3'd0;
            rx_sr       <= 7'd0;
            tx_sr       <= 8'd0;
            spi_ctrl_si <= 1'b0;
            spi_ctrl_so <= 1'b0;
            spi_ctrl_hd <= 1'b0;
            spi_ctrl_di <= 8'd0;
            epsel       <= '0;
        end else begin
            sclk_q      <= sclk_s;
            spi_ctrl_si <= 1'b0;
            spi_ctrl_hd <= 1'b0;
            spi_ctrl_so <= spi_ctrl_si;
            case (state)
                // The CSn synchroniser resets high, so wait for it to fill with
                // the real pin level before trusting a high CSn.
                ST_WAIT: begin
                    if (wait_cnt != 2'd2) wait_cnt <= wait_cnt + 2'd1;
                    else if (csn_s)       state    <= ST_IDLE;
                end
                ST_IDLE: begin
                    bit_cnt <= 3'd0;
                    if (!csn_s) begin
                        state <= ST_CMD;
                        tx_sr <= ID_EN ? ID_BYTE : 8'h00;
                    end
                end
                ST_CMD, ST_HDR, ST_DATA: begin
                    if (csn_s) begin
                        state   <= ST_IDLE;
                        bit_cnt <= 3'd0;
                        epsel   <= '0;
                    end else begin
                        if (sclk_rise) begin
                            rx_sr   <= rx_next[6:0];
                            bit_cnt <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) begin
                                if (state == ST_CMD) begin
                                    epsel <= cmd_dec;
                                    tx_sr <= 8'h00;
                                    state <= ST_HDR;
                                end else begin
                                    spi_ctrl_di <= rx_next;
                                    spi_ctrl_si <= 1'b1;
                                    spi_ctrl_hd <= (state == ST_HDR);
                                    state       <= ST_DATA;
                                end
                            end
                        end
                        // The fall after a byte's last rise must not shift, or
                        // the freshly loaded reply would lose its MSB.
                        if (spi_ctrl_so)
                            tx_sr <= spi_ctrl_do;
                        else if (sclk_fall && bit_cnt != 3'd0)
                            tx_sr <= {tx_sr[6:0], 1'b0};
                    end
                end
                default: state <= ST_WAIT;
            endcase
        end
    end

    assign spi_miso = (state == ST_CMD || state == ST_HDR || state == ST_DATA) ? tx_sr[7] : 1'b0;

endmodule

// File: tb/tb_ico_spi_ctrl.sv
// Directed bench for ico_spi_ctrl: host SPI driver, si/so monitor, byte scoreboard.
module tb_ico_spi_ctrl;

`ifdef ICO_SPI_CTRL_ID_EN
    localparam logic [7:0] EXP_ID = 8'hA5;
`else
    localparam logic [7:0] EXP_ID = 8'h00;
`endif

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       spi_sclk = 1'b0;
    logic       spi_csn = 1'b1;
    logic       spi_mosi = 1'b0;
    logic       spi_miso;
    logic       spi_ctrl_si, spi_ctrl_so, spi_ctrl_hd;
    logic [7:0] spi_ctrl_di;
    logic [7:0] spi_ctrl_do = 8'h00;
    logic [1:0] epsel;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc = 0;
    int last_rise_cyc = 0;
    logic prev_si = 1'b0;
    logic [8:0] exp_q[$];
    logic [8:0] got_q[$];
    logic [7:0] rd;

    ico_spi_ctrl #(.NUM_EP(2)) dut (
        .clk(clk), .resetn(resetn),
        .spi_sclk(spi_sclk), .spi_csn(spi_csn), .spi_mosi(spi_mosi), .spi_miso(spi_miso),
        .spi_ctrl_si(spi_ctrl_si), .spi_ctrl_so(spi_ctrl_so), .spi_ctrl_hd(spi_ctrl_hd),
        .spi_ctrl_di(spi_ctrl_di), .spi_ctrl_do(spi_ctrl_do), .epsel(epsel)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Monitor: collect si bytes, check si latency and that so trails si by one cycle.
    always @(negedge clk) begin
        if (resetn) begin
            if (prev_si || spi_ctrl_so) check("so_after_si", 32'(spi_ctrl_so), 32'(prev_si));
            if (spi_ctrl_si) begin
                got_q.push_back({spi_ctrl_hd, spi_ctrl_di});
                check("si_latency", 32'(cyc - last_rise_cyc), 32'd3);
            end
        end
        prev_si = resetn & spi_ctrl_si;
    end

    task automatic spi_xfer(input logic [7:0] mo, input int nbits, output logic [7:0] mi);
        mi = 8'h00;
        for (int i = 7; i > 7 - nbits; i--) begin
            spi_mosi = mo[i];
            repeat (5) @(negedge clk);
            mi = {mi[6:0], spi_miso};
            spi_sclk = 1'b1;
            last_rise_cyc = cyc;
            repeat (5) @(negedge clk);
            spi_sclk = 1'b0;
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic cs_low();
        spi_csn = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    task automatic cs_high(input logic [1:0] ep_before);
        spi_csn = 1'b1;
        repeat (2) @(negedge clk);
        check("epsel_hold_2cyc", 32'(epsel), 32'(ep_before));
        @(negedge clk);
        check("epsel_clr_3cyc", 32'(epsel), 32'd0);
        repeat (5) @(negedge clk);
    endtask

    task automatic check_sb(input string tag);
        check({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
        while (got_q.size() > 0 && exp_q.size() > 0)
            check(tag, 32'(got_q.pop_front()), 32'(exp_q.pop_front()));
        got_q.delete();
        exp_q.delete();
    endtask

    initial begin
        // Reset values
        repeat (3) @(negedge clk);
        check("rst_miso", 32'(spi_miso), 32'd0);
        check("rst_si", 32'(spi_ctrl_si), 32'd0);
        check("rst_so", 32'(spi_ctrl_so), 32'd0);
        check("rst_hd", 32'(spi_ctrl_hd), 32'd0);
        check("rst_di", 32'(spi_ctrl_di), 32'd0);
        check("rst_epsel", 32'(epsel), 32'd0);
        resetn = 1'b1;
        repeat (8) @(negedge clk);

        // Endpoint 1 with header and two data bytes
        exp_q.push_back({1'b1, 8'h04});
        exp_q.push_back({1'b0, 8'h12});
        exp_q.push_back({1'b0, 8'h34});
        cs_low();
        spi_xfer(8'h01, 8, rd);
        check("id_read", 32'(rd), 32'(EXP_ID));
        check("epsel_ep1", 32'(epsel), 32'h1);
        spi_xfer(8'h04, 8, rd);
        spi_xfer(8'h12, 8, rd);
        spi_xfer(8'h34, 8, rd);
        cs_high(2'b01);
        check_sb("t1_bytes");
        check("di_hold", 32'(spi_ctrl_di), 32'h34);

        // Out-of-range command still strobes the header
        exp_q.push_back({1'b1, 8'h10});
        cs_low();
        spi_xfer(8'h03, 8, rd);
        check("epsel_cmd3", 32'(epsel), 32'h0);
        spi_xfer(8'h10, 8, rd);
        check("epsel_cmd3_hdr", 32'(epsel), 32'h0);
        cs_high(2'b00);
        check_sb("t2_bytes");

        // Peripheral reply returned on MISO during the following byte
        spi_ctrl_do = 8'h5A;
        exp_q.push_back({1'b1, 8'h00});
        exp_q.push_back({1'b0, 8'h77});
        cs_low();
        spi_xfer(8'h01, 8, rd);
        spi_xfer(8'h00, 8, rd);
        check("hdr_read", 32'(rd), 32'h00);
        spi_xfer(8'h77, 8, rd);
        check("reply_read", 32'(rd), 32'h5A);
        cs_high(2'b01);
        check_sb("t3_bytes");
        spi_ctrl_do = 8'h00;

        // CSn rises after 5 bits of a data byte
        exp_q.push_back({1'b1, 8'h55});
        cs_low();
        spi_xfer(8'h02, 8, rd);
        check("epsel_ep2", 32'(epsel), 32'h2);
        spi_xfer(8'h55, 8, rd);
        spi_xfer(8'hC3, 5, rd);
        cs_high(2'b10);
        check_sb("t4_partial");
        exp_q.push_back({1'b1, 8'h66});
        cs_low();
        spi_xfer(8'h01, 8, rd);
        check("epsel_after_abort", 32'(epsel), 32'h1);
        spi_xfer(8'h66, 8, rd);
        cs_high(2'b01);
        check_sb("t4_next");

        // Asynchronous reset mid-header with CSn held low
        cs_low();
        spi_xfer(8'h02, 8, rd);
        spi_xfer(8'hF0, 4, rd);
        resetn = 1'b0;
        #1;
        check("amid_rst_epsel", 32'(epsel), 32'h0);
        check("amid_rst_di", 32'(spi_ctrl_di), 32'h0);
        check("amid_rst_miso", 32'(spi_miso), 32'h0);
        @(negedge clk);
        resetn = 1'b1;
        repeat (3) @(negedge clk);
        spi_xfer(8'h01, 8, rd);
        spi_xfer(8'h44, 8, rd);
        check("wait_epsel", 32'(epsel), 32'h0);
        check_sb("t5_ignored");
        spi_csn = 1'b1;
        repeat (8) @(negedge clk);
        exp_q.push_back({1'b1, 8'h20});
        cs_low();
        spi_xfer(8'h02, 8, rd);
        check("epsel_post_rst", 32'(epsel), 32'h2);
        spi_xfer(8'h20, 8, rd);
        cs_high(2'b10);
        check_sb("t5_resume");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ico_spi_ctrl.md
# ico_spi_ctrl

SPI slave front end for the icoboard control bus. It deserialises host SPI traffic, decodes a command byte into a one-hot endpoint select, and presents the header and data bytes to peripherals on the `spi_ctrl_*` byte bus. It also serialises peripheral reply bytes back onto MISO. It sits directly upstream of the servo PWM and other endpoint peripherals and drives their `spi_ctrl_si/so/hd/di` and `epsel` inputs.

## Interface
- `NUM_EP`, 2, number of endpoints; `epsel` width; valid command values are 1..`NUM_EP`.
- `ID_BYTE`, 8'hA5, identification byte returned on MISO during the command byte (only when `ICO_SPI_CTRL_ID_EN` is defined).
- `clk`  in  1  system clock.
- `resetn`  in  1  reset, asynchronous, active-low.
- `spi_sclk`  in  1  host SPI clock, mode 0, asynchronous to `clk`.
- `spi_csn`  in  1  host chip select, active-low, asynchronous.
- `spi_mosi`  in  1  host data in, MSB first.
- `spi_miso`  out  1  data to host, MSB first.
- `spi_ctrl_si`  out  1  one-cycle strobe: byte on `spi_ctrl_di` is valid.
- `spi_ctrl_so`  out  1  one-cycle strobe: `spi_ctrl_do` is sampled this cycle.
- `spi_ctrl_hd`  out  1  qualifies `spi_ctrl_si`: current byte is the header byte.
- `spi_ctrl_di`  out  8  received byte.
- `spi_ctrl_do`  in  8  reply byte from the selected peripheral.
- `epsel`  out  `NUM_EP`  one-hot endpoint select.

## Operation
- `spi_sclk`, `spi_csn` and `spi_mosi` each pass through 2-flop synchronisers. One further register on the synchronised SCLK detects rising and falling edges.
- States:
  - WAIT: after reset, hold until synchronised CSn is seen high, then go to IDLE.
  - IDLE: CSn high.
  - CMD: first byte after CSn falls.
  - HDR: second byte.
  - DATA: all later bytes.
- State transitions:
  - IDLE→CMD on synchronised CSn falling.
  - CMD→HDR on the 8th rising SCLK edge.
  - HDR→DATA on the 8th rising SCLK edge.
  - DATA→DATA on each byte.
  - Any state except WAIT→IDLE on synchronised CSn rising.
- MOSI is sampled on each synchronised SCLK rising edge into a 3-bit bit counter and an 8-bit shift register.
- Command byte completion:
  - Value c in 1..`NUM_EP`: `epsel` = 1<<(c-1).
  - Any other value: `epsel` = 0.
  - No `si` strobe is issued for the command byte.
- HDR byte completion: `spi_ctrl_di` ← byte, `si`=1 and `hd`=1 for one cycle.
- DATA byte completion: `spi_ctrl_di` ← byte, `si`=1 and `hd`=0 for one cycle.
- HDR and DATA bytes are strobed even when `epsel`=0; peripherals gate on `epsel`.
- `spi_ctrl_di` holds its value until the next completed byte.
- `so` pulses in the cycle after each `si`. In that cycle `spi_ctrl_do` is latched into the TX shift register and shifted out during the following byte.
- TX register loads:
  - On CSn fall: `ID_BYTE` or 0 (see Configuration).
  - At CMD completion: 0.
- MISO:
  - Presents the TX register MSB.
  - Shifts on each synchronised SCLK falling edge.
  - Drives 0 in IDLE and WAIT.
- CSn rising mid-byte: partial byte discarded, no `si`, bit counter cleared, `epsel` cleared.

## Timing
- Reset values: `spi_miso`=0, `si`=0, `so`=0, `hd`=0, `di`=0, `epsel`=0, state=WAIT.
- `si`, `hd` and `di` become valid exactly 3 `clk` cycles after the pin-level 8th SCLK rising edge (2 sync + 1 edge detect).
- `epsel` updates with the same 3-cycle latency after command byte completion. It is cleared 3 cycles after the pin-level CSn rise.
- `so` = `si` delayed by 1 cycle. A peripheral must present `spi_ctrl_do` combinationally or within 1 cycle of `si`.
- SCLK high and low phases must each be ≥4 `clk` cycles. CSn setup to the first SCLK rise must be ≥4 `clk` cycles.
- MISO changes ≤3 `clk` cycles after SCLK falls, so it is valid well before the next rising edge.
- Asynchronous reset mid-transaction: all outputs go to reset values immediately. Bytes are ignored until CSn high is observed (WAIT).

## Configuration
- `ICO_SPI_CTRL_ID_EN` defined: TX register loads `ID_BYTE` at CSn fall, so the host reads `ID_BYTE` while sending the command byte.
- `ICO_SPI_CTRL_ID_EN` undefined: TX register loads 0 at CSn fall; `ID_BYTE` is unused.

## Structure
- Package `ico_spi_ctrl_pkg`: state enum (WAIT, IDLE, CMD, HDR, DATA) and default `ID_BYTE` constant.
- Sub-module `ico_sync2`: 2-flop synchroniser with async active-low reset. Instantiated once each for SCLK, CSn and MOSI, with reset values 0, 1 and 0 respectively.

## Test plan
- CSn low, send 0x01,0x04,0x12,0x34, CSn high → `epsel`=2'b01 from CMD end; three `si` pulses with `di`=0x04(`hd`=1), 0x12, 0x34(`hd`=0); `epsel`=0 3 cycles after CSn rise.
- Send command 0x03 with `NUM_EP`=2, then 0x10 → `epsel` stays 0; one `si` with `hd`=1, `di`=0x10.
- Peripheral drives `do`=0x5A at `so` after header 0x00; host sends next byte → MISO returns 0x5A MSB first; host read during header byte = 0x00.
- CSn rises after 5 bits of a DATA byte → no `si`; `epsel`=0; next transaction decodes its command correctly.
- Assert `resetn` low with CSn low mid-byte, release, clock 8 more bits → no `si`, `epsel`=0; after CSn high then low, 0x02 → `epsel`=2'b10.
- With `ICO_SPI_CTRL_ID_EN`, host reads 0xA5 during command byte; without it, host reads 0x00.
